// File: rtl/cell_comm_pkg.sv
// Shared types and constants for the cell communication TX arbiter.
// Holds the arbiter state encoding, the grant-index constants and the
// width of the per-packet word counter.
package cell_comm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOC   = 2'd1,
      FWD   = 2'd2,
      FLUSH = 2'd3
   } arb_state_e;

   localparam logic GRANT_LOC = 1'b0;
   localparam logic GRANT_FWD = 1'b1;

   localparam int WORD_CNT_W = 8;

endpackage

// File: rtl/cell_comm_sat_counter.sv
// Saturating event counter: counts up by one on each cycle with inc high
// and sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   counter clock
//   rst_n  in   asynchronous active-low reset, clears the count
//   inc    in   count-enable for this cycle
//   value  out  current count
module cell_comm_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] value
);

   logic [CNT_WIDTH-1:0] value_q;
   logic [CNT_WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1)) begin
         value_d = value_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/cell_comm_tx_arbiter.sv
// Packet-atomic round-robin arbiter between the local FA packet source and
// the forwarded-packet source, feeding the Aurora TX AXIS port. Oversized
// packets are truncated (forced tlast) and their tail discarded; a channel
// loss mid-packet drains the rest of the packet from the source.
//
// Build option: define CELL_COMM_TX_ARB_STATS_EN to implement the abort and
// truncation event counters; otherwise both count outputs are tied to 0.
//
// Ports:
//   auUserClk, auResetN             clock, async active-low reset
//   channelUp                       Aurora channel up
//   locT{valid,last,data}/locTready local source AXIS
//   fwdT{valid,last,data}/fwdTready forwarded source AXIS
//   txT{valid,last,data}/txTready   Aurora TX AXIS
//   grantLoc, grantFwd              current owner of the TX path
//   abortCount, truncCount          saturating event counters
//
// state | meaning
// IDLE  | no owner; picks a source when channelUp and a source is valid
// LOC   | local source streams straight through to TX
// FWD   | forwarded source streams straight through to TX
// FLUSH | TX idle; owner's remaining words are accepted and dropped to tlast
module cell_comm_tx_arbiter
   import cell_comm_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_PKT_WORDS = 16,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  auUserClk,
   input  logic                  auResetN,
   input  logic                  channelUp,
   input  logic                  locTvalid,
   input  logic                  locTlast,
   input  logic [DATA_WIDTH-1:0] locTdata,
   output logic                  locTready,
   input  logic                  fwdTvalid,
   input  logic                  fwdTlast,
   input  logic [DATA_WIDTH-1:0] fwdTdata,
   output logic                  fwdTready,
   output logic                  txTvalid,
   output logic                  txTlast,
   output logic [DATA_WIDTH-1:0] txTdata,
   input  logic                  txTready,
   output logic                  grantLoc,
   output logic                  grantFwd,
   output logic [CNT_WIDTH-1:0]  abortCount,
   output logic [CNT_WIDTH-1:0]  truncCount
);

   // Index of the last allowed word, counted from zero.
   localparam logic [WORD_CNT_W-1:0] TRUNC_IDX = WORD_CNT_W'(MAX_PKT_WORDS - 1);

   arb_state_e              state_q, state_d;
   // Owner of the most recent grant. Doubles as the round-robin flag: the
   // other source wins the next tie. Resets to FWD so LOC wins first.
   logic                    last_gnt_q, last_gnt_d;
   logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;

   logic                    src_valid;
   logic                    src_last;
   logic [DATA_WIDTH-1:0]   src_data;
   logic                    src_ready;
   logic                    trunc_hit;
   logic                    tx_beat;

   assign src_valid = (last_gnt_q == GRANT_FWD) ? fwdTvalid : locTvalid;
   assign src_last  = (last_gnt_q == GRANT_FWD) ? fwdTlast  : locTlast;
   assign src_data  = (last_gnt_q == GRANT_FWD) ? fwdTdata  : locTdata;
   assign trunc_hit = (word_cnt_q == TRUNC_IDX);
   assign tx_beat   = txTvalid & txTready;

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      word_cnt_d = word_cnt_q;
      txTvalid   = 1'b0;
      txTlast    = 1'b0;
      txTdata    = src_data;
      src_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            word_cnt_d = '0;
            if (channelUp) begin
               if (locTvalid && (!fwdTvalid || (last_gnt_q == GRANT_FWD))) begin
                  state_d    = LOC;
                  last_gnt_d = GRANT_LOC;
               end else if (fwdTvalid) begin
                  state_d    = FWD;
                  last_gnt_d = GRANT_FWD;
               end
            end
         end
         LOC, FWD: begin
            txTvalid  = src_valid;
            txTlast   = src_last | trunc_hit;
            src_ready = txTready;
            if (tx_beat && src_last) begin
               state_d    = IDLE;
               word_cnt_d = '0;
            end else if (tx_beat && trunc_hit) begin
               state_d = FLUSH;
            end else if (!channelUp) begin
               state_d = FLUSH;
            end else if (tx_beat) begin
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end
         FLUSH: begin
            src_ready = 1'b1;
            if (src_valid && src_last) begin
               state_d    = IDLE;
               word_cnt_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge auUserClk or negedge auResetN) begin
      if (!auResetN) begin
         state_q    <= IDLE;
         last_gnt_q <= GRANT_FWD;
         word_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         word_cnt_q <= word_cnt_d;
      end
   end

   assign locTready = src_ready & (last_gnt_q == GRANT_LOC);
   assign fwdTready = src_ready & (last_gnt_q == GRANT_FWD);
   assign grantLoc  = (state_q != IDLE) & (last_gnt_q == GRANT_LOC);
   assign grantFwd  = (state_q != IDLE) & (last_gnt_q == GRANT_FWD);

`ifdef CELL_COMM_TX_ARB_STATS_EN
   logic in_pkt;
   logic trunc_inc;
   logic abort_inc;

   assign in_pkt    = (state_q == LOC) || (state_q == FWD);
   assign trunc_inc = in_pkt & tx_beat & trunc_hit & ~src_last;
   // A loss on the same cycle as a tlast handshake (real or forced) is not an abort.
   assign abort_inc = in_pkt & ~channelUp & ~(tx_beat & (src_last | trunc_hit));

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_abort_cnt (
      .clk   (auUserClk),
      .rst_n (auResetN),
      .inc   (abort_inc),
      .value (abortCount)
   );

   cell_comm_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_trunc_cnt (
      .clk   (auUserClk),
      .rst_n (auResetN),
      .inc   (trunc_inc),
      .value (truncCount)
   );
`else
   assign abortCount = '0;
   assign truncCount = '0;
`endif

endmodule

// File: tb/tb_cell_comm_tx_arbiter.sv
// Bench for cell_comm_tx_arbiter: packet sources driven from length queues,
// a packet-level reference model of the arbiter, per-cycle output compare,
// directed scenarios with literal expectations, then a randomized soak.
module tb_cell_comm_tx_arbiter;

   localparam int DW   = 32;
   localparam int MAXW = 16;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;
`ifdef CELL_COMM_TX_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          auUserClk = 1'b0;
   logic          auResetN  = 1'b0;
   logic          channelUp = 1'b0;
   logic          locTvalid = 1'b0, locTlast = 1'b0;
   logic [DW-1:0] locTdata  = '0;
   logic          locTready;
   logic          fwdTvalid = 1'b0, fwdTlast = 1'b0;
   logic [DW-1:0] fwdTdata  = '0;
   logic          fwdTready;
   logic          txTvalid, txTlast;
   logic [DW-1:0] txTdata;
   logic          txTready = 1'b0;
   logic          grantLoc, grantFwd;
   logic [CW-1:0] abortCount, truncCount;

   always #5 auUserClk = ~auUserClk;

   cell_comm_tx_arbiter #(
      .DATA_WIDTH(DW), .MAX_PKT_WORDS(MAXW), .CNT_WIDTH(CW)
   ) dut (
      .auUserClk(auUserClk), .auResetN(auResetN), .channelUp(channelUp),
      .locTvalid(locTvalid), .locTlast(locTlast), .locTdata(locTdata), .locTready(locTready),
      .fwdTvalid(fwdTvalid), .fwdTlast(fwdTlast), .fwdTdata(fwdTdata), .fwdTready(fwdTready),
      .txTvalid(txTvalid), .txTlast(txTlast), .txTdata(txTdata), .txTready(txTready),
      .grantLoc(grantLoc), .grantFwd(grantFwd),
      .abortCount(abortCount), .truncCount(truncCount)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- packet sources ----------------
   int  pkt_q0[$];
   int  pkt_q1[$];
   bit  s_busy[2];
   bit  s_v[2];
   int  s_len[2], s_idx[2], s_pid[2];
   int  valid_pct = 100;
   int  tx_mode   = 0;     // 0: always ready, 1: toggle, 2: random
   int  tx_pct    = 75;
   bit  tx_tog    = 1'b1;
   bit  ch_up_knob = 1'b1;

   // ---------------- reference model ----------------
   int  m_mode;            // 0 no owner, 1 streaming, 2 draining
   int  m_own;             // 0 local, 1 forwarded
   int  m_sent;            // words already sent in the current packet
   int  m_last_own;        // owner of the latest grant
   int  m_abort, m_trunc;

   logic [31:0] log_d[$];
   bit          log_l[$];
   int          log_cyc[$];
   int          cyc;

   function automatic logic [31:0] word_of(input int i);
      return {8'(i), 8'(s_pid[i]), 16'(s_idx[i])};
   endfunction

   function automatic bit is_last(input int i);
      return s_v[i] && (s_idx[i] == s_len[i] - 1);
   endfunction

   function automatic int sat_inc(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   task automatic src_gen();
      for (int i = 0; i < 2; i++) begin
         if (!s_busy[i]) begin
            if (i == 0 && pkt_q0.size() > 0) begin
               s_busy[0] = 1'b1; s_len[0] = pkt_q0.pop_front(); s_idx[0] = 0; s_v[0] = 1'b0;
            end else if (i == 1 && pkt_q1.size() > 0) begin
               s_busy[1] = 1'b1; s_len[1] = pkt_q1.pop_front(); s_idx[1] = 0; s_v[1] = 1'b0;
            end
         end
         if (s_busy[i] && !s_v[i] && ($urandom_range(99) < valid_pct)) s_v[i] = 1'b1;
      end
   endtask

   task automatic drive();
      locTvalid = s_v[0]; locTlast = is_last(0); locTdata = word_of(0);
      fwdTvalid = s_v[1]; fwdTlast = is_last(1); fwdTdata = word_of(1);
      channelUp = ch_up_knob;
      case (tx_mode)
         0: txTready = 1'b1;
         1: begin txTready = tx_tog; tx_tog = ~tx_tog; end
         default: txTready = ($urandom_range(99) < tx_pct);
      endcase
   endtask

   task automatic step();
      bit          v[2], l[2], er[2], eg[2], hs[2];
      bit          ev, el, beat;
      logic [31:0] ed;
      drive();
      @(negedge auUserClk);
      for (int i = 0; i < 2; i++) begin
         v[i] = s_v[i]; l[i] = is_last(i); er[i] = 1'b0; eg[i] = 1'b0;
      end
      ev = 1'b0; el = 1'b0; ed = '0;
      if (m_mode == 1) begin
         ev = v[m_own];
         el = l[m_own] || (m_sent == MAXW - 1);
         ed = word_of(m_own);
         er[m_own] = txTready;
         eg[m_own] = 1'b1;
      end else if (m_mode == 2) begin
         er[m_own] = 1'b1;
         eg[m_own] = 1'b1;
      end
      chk("txTvalid", txTvalid, ev);
      if (ev) begin
         chk("txTlast", txTlast, el);
         chk("txTdata", txTdata, ed);
      end
      chk("locTready", locTready, er[0]);
      chk("fwdTready", fwdTready, er[1]);
      chk("grantLoc", grantLoc, eg[0]);
      chk("grantFwd", grantFwd, eg[1]);
      chk("abortCount", abortCount, STATS ? m_abort : 0);
      chk("truncCount", truncCount, STATS ? m_trunc : 0);

      beat = ev && txTready;
      if (beat) begin
         log_d.push_back(ed); log_l.push_back(el); log_cyc.push_back(cyc);
      end
      for (int i = 0; i < 2; i++) hs[i] = v[i] && er[i];

      case (m_mode)
         0: if (ch_up_knob && (v[0] || v[1])) begin
               if (v[0] && v[1]) m_own = (m_last_own == 0) ? 1 : 0;
               else              m_own = v[0] ? 0 : 1;
               m_last_own = m_own;
               m_mode = 1;
               m_sent = 0;
            end
         1: if (beat && l[m_own]) m_mode = 0;
            else if (beat && m_sent == MAXW - 1) begin m_mode = 2; m_trunc = sat_inc(m_trunc); end
            else if (!ch_up_knob) begin m_mode = 2; m_abort = sat_inc(m_abort); end
            else if (beat) m_sent++;
         default: if (v[m_own] && l[m_own]) m_mode = 0;
      endcase

      @(posedge auUserClk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (hs[i]) begin
            if (l[i]) begin
               s_busy[i] = 1'b0; s_v[i] = 1'b0; s_pid[i]++;
            end else begin
               s_idx[i]++;
               s_v[i] = ($urandom_range(99) < valid_pct);
            end
         end
      end
      cyc++;
      src_gen();
   endtask

   // Asserts reset from a point away from the clock edge, checks outputs are
   // already quiet, then releases between edges. Sources abandon their packets.
   task automatic do_reset();
      auResetN = 1'b0;
      #1;
      chk("rst_txTvalid", txTvalid, 0);
      chk("rst_txTlast", txTlast, 0);
      chk("rst_locTready", locTready, 0);
      chk("rst_fwdTready", fwdTready, 0);
      chk("rst_grantLoc", grantLoc, 0);
      chk("rst_grantFwd", grantFwd, 0);
      chk("rst_abortCount", abortCount, 0);
      chk("rst_truncCount", truncCount, 0);
      pkt_q0.delete(); pkt_q1.delete();
      for (int i = 0; i < 2; i++) begin
         s_busy[i] = 1'b0; s_v[i] = 1'b0; s_pid[i] = 0; s_idx[i] = 0; s_len[i] = 1;
      end
      m_mode = 0; m_own = 0; m_sent = 0; m_last_own = 1; m_abort = 0; m_trunc = 0;
      log_d.delete(); log_l.delete(); log_cyc.delete();
      valid_pct = 100; tx_mode = 0; tx_tog = 1'b1; ch_up_knob = 1'b1;
      drive();
      repeat (2) @(posedge auUserClk);
      @(negedge auUserClk);
      auResetN = 1'b1;
      @(posedge auUserClk);
      #1;
      cyc = 0;
   endtask

   logic [31:0] exp_t1[8];
   logic [31:0] exp_t2[7];

   initial begin
      exp_t1 = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                 32'h0100_0000, 32'h0100_0001, 32'h0100_0002, 32'h0100_0003};
      exp_t2 = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                 32'h0100_0000, 32'h0100_0001, 32'h0100_0002};

      // Simultaneous 4-word packets: LOC first, then FWD, no interleave.
      do_reset();
      pkt_q0.push_back(4); pkt_q1.push_back(4);
      src_gen();
      repeat (14) step();
      chk("t1_beats", log_d.size(), 8);
      if (log_d.size() == 8) begin
         for (int k = 0; k < 8; k++) chk("t1_data", log_d[k], exp_t1[k]);
         chk("t1_first_latency", log_cyc[0], 1);
         chk("t1_loc_contig", log_cyc[3] - log_cyc[0], 3);
         chk("t1_fwd_contig", log_cyc[7] - log_cyc[4], 3);
         // One IDLE cycle separates the two packets.
         chk("t1_gap", log_cyc[4] - log_cyc[3], 2);
         chk("t1_last_loc", log_l[3], 1);
         chk("t1_last_fwd", log_l[7], 1);
      end

      // txTready toggling during a LOC packet with FWD waiting.
      do_reset();
      tx_mode = 1; tx_tog = 1'b1;
      pkt_q0.push_back(4); pkt_q1.push_back(3);
      src_gen();
      repeat (20) step();
      chk("t2_beats", log_d.size(), 7);
      if (log_d.size() == 7) begin
         for (int k = 0; k < 7; k++) chk("t2_data", log_d[k], exp_t2[k]);
      end

      // 20-word packet truncated at word 16, tail flushed.
      do_reset();
      pkt_q0.push_back(20);
      src_gen();
      repeat (30) step();
      chk("t3_beats", log_d.size(), 16);
      if (log_d.size() == 16) begin
         chk("t3_forced_last", log_l[15], 1);
         chk("t3_no_early_last", log_l[14], 0);
         chk("t3_word16", log_d[15], 32'h0000_000F);
      end
      chk("t3_truncCount", truncCount, STATS ? 1 : 0);
      chk("t3_drained", s_busy[0], 0);
      chk("t3_grant_released", grantLoc, 0);

      // Channel loss on word 2 of a 6-word FWD packet.
      do_reset();
      pkt_q1.push_back(6);
      src_gen();
      for (int k = 0; k < 20 && log_d.size() < 1; k++) step();
      chk("t4_started", log_d.size(), 1);
      ch_up_knob = 1'b0;
      step();
      repeat (8) step();
      ch_up_knob = 1'b1;
      step();
      chk("t4_beats", log_d.size(), 2);
      chk("t4_abortCount", abortCount, STATS ? 1 : 0);
      chk("t4_drained", s_busy[1], 0);
      chk("t4_idle", grantFwd, 0);

      // Reset mid-packet, then a tie must go to LOC again.
      do_reset();
      pkt_q0.push_back(8);
      src_gen();
      repeat (4) step();
      do_reset();
      pkt_q0.push_back(2); pkt_q1.push_back(2);
      src_gen();
      repeat (8) step();
      chk("t5_beats", log_d.size(), 4);
      if (log_d.size() == 4) begin
         chk("t5_first_is_loc", log_d[0][31:24], 8'h00);
         chk("t5_then_fwd", log_d[2][31:24], 8'h01);
      end

      // Randomized soak: gaps, back-pressure, channel drops, long packets.
      do_reset();
      valid_pct = 70; tx_mode = 2; tx_pct = 75;
      for (int c = 0; c < 5000; c++) begin
         if (pkt_q0.size() == 0 && $urandom_range(9) == 0) pkt_q0.push_back($urandom_range(1, 20));
         if (pkt_q1.size() == 0 && $urandom_range(9) == 0) pkt_q1.push_back($urandom_range(1, 20));
         if (ch_up_knob) begin
            if ($urandom_range(99) < 3) ch_up_knob = 1'b0;
         end else if ($urandom_range(99) < 30) begin
            ch_up_knob = 1'b1;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cell_comm_tx_arbiter.md
CELL_COMM_TX_ARBITER -- requirements
Module: cell_comm_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the AXIS tdata width.
REQ-002 Parameter MAX_PKT_WORDS, default 16, is the maximum number of words per packet before forced truncation (legal range 2..255).
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the statistics counters.
REQ-004 Port list SHALL be exactly as follows; one clock, reset asynchronous active-low:
- auUserClk  in  1  Aurora user clock; all logic is on its rising edge.
- auResetN  in  1  asynchronous active-low reset.
- channelUp  in  1  Aurora channel-up, synchronous to auUserClk.
- locTvalid/locTlast/locTdata  in  1/1/DATA_WIDTH  local FA packet source.
- locTready  out  1  local source ready.
- fwdTvalid/fwdTlast/fwdTdata  in  1/1/DATA_WIDTH  forwarded-packet source (from the opposite ring direction).
- fwdTready  out  1  forwarded source ready.
- txTvalid/txTlast/txTdata  out  1/1/DATA_WIDTH  to Aurora TX AXIS.
- txTready  in  1  Aurora TX ready.
- grantLoc/grantFwd  out  1/1  current grant, one-hot or both 0.
- abortCount/truncCount  out  CNT_WIDTH/CNT_WIDTH  saturating event counters.

Function
REQ-005 States: IDLE, LOC, FWD, FLUSH; encoding from the package.
REQ-006 IDLE: no tready, txTvalid=0; with channelUp=1, a valid source moves to LOC/FWD on the next edge.
REQ-007 Simultaneous locTvalid and fwdTvalid in IDLE: grant the source not granted last (round-robin flag); after reset, LOC wins first.
REQ-008 LOC/FWD: tx* = granted source's signals combinationally; granted tready = txTready; other tready = 0.
REQ-009 Latency: first word appears on tx one cycle after the source asserts tvalid in IDLE; no bubbles within a packet.
REQ-010 Grant is packet-atomic: held until a beat with tlast handshakes (txTvalid & txTready & txTlast), then IDLE on the next edge; the round-robin flag is updated at the same time.
REQ-011 A word counter (8 bits) increments on each accepted beat and clears on return to IDLE.
REQ-012 Truncation: on the accepted beat that is word MAX_PKT_WORDS without source tlast, txTlast is forced to 1, truncCount increments, and the next state is FLUSH.
REQ-013 Channel loss: channelUp=0 in LOC/FWD moves the block to FLUSH on the next edge; abortCount increments unless the loss coincides with a tlast handshake, in which case the next state is IDLE.
REQ-014 FLUSH: txTvalid=0; granted source tready=1; source words are discarded until a tlast beat, then IDLE.
REQ-015 channelUp=0 in IDLE holds IDLE; all tready stay 0 (upstream back-pressured).
REQ-016 Counters saturate at all-ones and never wrap.

Reset
REQ-017 auResetN low asynchronously forces IDLE, word counter 0, round-robin flag to "LOC next", and both counters 0.
REQ-018 During reset all tready, txTvalid, txTlast, grantLoc and grantFwd are 0; a packet in progress is abandoned, not flushed.
REQ-019 Reset deassertion is synchronised externally; the block takes no action on the first edge after release beyond IDLE evaluation.

Configuration
REQ-020 Macro CELL_COMM_TX_ARB_STATS_EN defined: abortCount and truncCount are implemented as specified.
REQ-021 Macro CELL_COMM_TX_ARB_STATS_EN undefined: no counter flops; both outputs tied to 0; the arbitration, truncation and flush behaviour is unchanged.

Structure
REQ-022 Package cell_comm_pkg SHALL hold the state enum typedef (IDLE, LOC, FWD, FLUSH) and the grant-index constants GRANT_LOC=0 and GRANT_FWD=1.
REQ-023 One sub-module, cell_comm_sat_counter (CNT_WIDTH, inc in, value out, async active-low reset), is instantiated twice when stats are enabled.

Verification
REQ-024 Both sources present 4-word packets on the same cycle after reset -> LOC packet first, then FWD, with no interleaving and 8 contiguous tx beats when txTready=1.
REQ-025 txTready toggles 1,0,1,0 during a LOC packet -> locTready mirrors txTready; fwdTready stays 0; tx data order is preserved.
REQ-026 20-word packet with MAX_PKT_WORDS=16 -> txTlast is asserted on word 16, words 17-20 are flushed, and truncCount=1.
REQ-027 channelUp drops after word 2 of a 6-word FWD packet -> txTvalid=0 next cycle, remaining 4 words are drained, abortCount=1, state returns to IDLE.
REQ-028 auResetN asserted mid-packet, then released -> outputs are 0 immediately, counters are 0, and the next simultaneous request grants LOC.
REQ-029 Build without CELL_COMM_TX_ARB_STATS_EN, rerun REQ-026 -> truncation behaviour is identical and truncCount reads 0.
